seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Parametrised, iterative (radix-2 shift-add) successor to the team's combinational 32x32 unsigned multiplier.
- Adds a per-transaction signed/unsigned mode selected by `in_signed`.
- Uses valid/ready handshakes on both input and output and holds the result under backpressure.
- Sits between the ALU issue logic and the writeback path; trades latency for area.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits; legal values are 4 to 64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived from WIDTH, not overridden.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands are presented.
- in_ready  output  1  block can accept operands.
- in1  input  WIDTH  multiplicand.
- in2  input  WIDTH  multiplier.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts the product.
- out  output  2*WIDTH  product.
- busy  output  1  high while in the BUSY state.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. Reset overrides all other inputs in that cycle.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out=0, counter=0, internal registers=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. When in_valid=1, the accept edge E0 loads the registers and moves to BUSY.
  - BUSY: in_ready=0, busy=1. One multiplier bit is processed per edge. After the WIDTH-th BUSY edge, moves to DONE.
  - DONE: out_valid=1, in_ready=0. When out_ready=1, that edge moves to IDLE and clears out_valid.
- Load at accept:
  - mag_a = |in1| and mag_b = |in2| if in_signed, else in1 and in2 zero-extended.
  - neg = in_signed & (in1[MSB] ^ in2[MSB]).
  - acc = 0, counter = 0.
- Iteration (each BUSY edge):
  - if mag_b[0], acc += mcand, where mcand is mag_a zero-extended to 2*WIDTH.
  - mcand <<= 1; mag_b >>= 1; counter++.
- Finalisation (transition to DONE): out = neg ? -acc_next : acc_next, computed modulo 2^(2*WIDTH).
- Magnitude of the most negative value is 2^(WIDTH-1), which fits in the unsigned WIDTH-bit magnitude register. No overflow is possible.
- Latency: out_valid first rises exactly WIDTH cycles after the accept edge (after the E_WIDTH edge).
- Throughput: one product per WIDTH+2 cycles minimum (accept, WIDTH iterations, one DONE cycle with out_ready=1). There is no accept in DONE.
- Backpressure: in DONE with out_ready=0, `out` and out_valid hold stable indefinitely.
- Input stability: in1, in2 and in_signed are ignored outside the accept edge. Changes while BUSY have no effect.
- Reset mid-BUSY or mid-DONE: returns to IDLE next edge; the pending product is discarded and out_valid=0.
- in_valid while not in IDLE: ignored, no queueing. The producer holds in_valid until it sees in_ready.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined: at a BUSY edge where the shifted mag_b becomes 0, the block finalises and enters DONE immediately.
  - Latency = max(1, index of highest set bit of mag_b + 1) cycles.
  - mag_b=0 gives 1 cycle.
- Undefined: fixed WIDTH-cycle latency regardless of operands.

Decomposition:
- Package seq_mult_pkg holds:
  - typedef state_t {IDLE, BUSY, DONE};
  - localparam MIN_WIDTH=4, MAX_WIDTH=64.
  - function abs_w (conditional two's-complement magnitude).
- One natural sub-module: seq_mult_datapath (acc/mcand/mag_b registers, adder, sign fixup). The FSM stays in the top module.

Test Plan:
- Unsigned, WIDTH=32: in1=0xFFFFFFFF, in2=0xFFFFFFFF -> out=0xFFFFFFFE00000001; out_valid 32 cycles after accept.
- Signed: in1=0xFFFFFFFD (-3), in2=0x00000005 -> out=0xFFFFFFFFFFFFFFF1. Signed in1=in2=0x80000000 -> out=0x4000000000000000. The same operands unsigned -> out=0x4000000000000000; then in1=0x80000000, in2=0xFFFFFFFF unsigned -> 0x7FFFFFFF80000000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out and out_valid stable, in_ready=0. Assert out_ready -> IDLE next cycle and in_ready=1.
- Reset after 10 BUSY cycles -> next cycle state IDLE, out_valid=0, out=0. A new operation 7x6 then gives 42 with normal latency.
- Input change mid-BUSY: accept 3x5, then drive in1=in2=0xFFFFFFFF with in_valid=1 during BUSY -> result 15, no second transaction accepted.
- SEQ_MULT_EARLY_TERM_EN defined: 5x3 -> 15 after 2 cycles; 9x0 -> 0 after 1 cycle. Without the macro, both take 32 cycles.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 64;

  // Two's-complement magnitude when neg is set; the caller truncates to its width.
  function automatic logic [MAX_WIDTH-1:0] abs_w(input logic [MAX_WIDTH-1:0] v,
                                                 input logic                 neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Radix-2 shift-add datapath: accumulator, shifted multiplicand, multiplier bits, sign fixup.
// Exposes mag_b_last when SEQ_MULT_EARLY_TERM_EN is defined.
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               fin,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               in_signed,
`ifdef SEQ_MULT_EARLY_TERM_EN
  output logic               mag_b_last,
`endif
  output logic [2*WIDTH-1:0] out
);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] out_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mag_b_reg;
  logic               neg_reg;

  always_comb begin
    acc_next = mag_b_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      mcand_reg <= '0;
      mag_b_reg <= '0;
      neg_reg   <= 1'b0;
      out_reg   <= '0;
    end else if (load) begin
      mcand_reg <= {{WIDTH{1'b0}}, WIDTH'(abs_w(MAX_WIDTH'(in1), in_signed & in1[WIDTH-1]))};
      mag_b_reg <= WIDTH'(abs_w(MAX_WIDTH'(in2), in_signed & in2[WIDTH-1]));
      neg_reg   <= in_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
      acc_reg   <= '0;
    end else if (step) begin
      acc_reg   <= acc_next;
      mcand_reg <= mcand_reg << 1;
      mag_b_reg <= mag_b_reg >> 1;
      // The sign is applied on the final sum, modulo 2^(2*WIDTH).
      if (fin) begin
        out_reg <= neg_reg ? -acc_next : acc_next;
      end
    end
  end

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign mag_b_last = ((mag_b_reg >> 1) == '0);
`endif

  assign out = out_reg;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier with valid/ready on both sides; one bit per cycle.
// Optional early termination on exhausted multiplier bits: SEQ_MULT_EARLY_TERM_EN.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             load, step, fin, last;

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic mag_b_last;
  assign last = (cnt_reg == CNT_W'(WIDTH - 1)) || mag_b_last;
`else
  assign last = (cnt_reg == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    step       = 1'b0;
    fin        = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        busy     = 1'b1;
        step     = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (last) begin
          fin        = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  seq_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .fin        (fin),
    .in1        (in1),
    .in2        (in2),
    .in_signed  (in_signed),
`ifdef SEQ_MULT_EARLY_TERM_EN
    .mag_b_last (mag_b_last),
`endif
    .out        (out)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (WIDTH=32): products, latency, backpressure, reset, input stability.
module tb_seq_multiplier;

`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input int early_cycles);
    return EARLY ? early_cycles : 32;
  endfunction

  // Accept one operation and wait (bounded) for out_valid; leaves the block in DONE.
  task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp, input int exp_lat,
                         input bit junk);
    int guard;
    int cycles;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    in1 = a; in2 = b; in_signed = s; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    if (junk) begin
      in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF; in_signed = 1'b0;
    end else begin
      in_valid = 1'b0;
    end
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(posedge clk); @(negedge clk); cycles++;
    end
    in_valid = 1'b0;
    chk({tag, "_out"}, out, exp);
    chk({tag, "_lat"}, 64'(cycles), 64'(exp_lat));
    $display("txn %s: a=%h b=%h signed=%0d out=%h latency=%0d", tag, a, b, s, out, cycles);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out", out, 64'd0);

    do_mult("u_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 32, 1'b0);
    release_out("u_ffxff");
    do_mult("s_m3x5", 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, lat(3), 1'b0);
    release_out("s_m3x5");
    do_mult("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 32, 1'b0);
    release_out("s_minxmin");
    do_mult("u_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 32, 1'b0);
    release_out("u_minxmin");

    // Backpressure: hold out_ready low in DONE for 10 cycles.
    do_mult("u_8xff", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h7FFF_FFFF_8000_0000, 32, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      chk("bp_out", out, 64'h7FFF_FFFF_8000_0000);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    $display("txn backpressure: held 10 cycles out=%h", out);
    release_out("bp");

    // Reset after 10 BUSY cycles discards the operation.
    in1 = 32'd1234; in2 = 32'hFFFF_FFFF; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out", out, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    $display("txn mid_busy_reset: in_ready=%0d out_valid=%0d out=%h", in_ready, out_valid, out);
    do_mult("u_7x6", 32'd7, 32'd6, 1'b0, 64'd42, lat(3), 1'b0);
    release_out("u_7x6");

    // Operand changes with in_valid held during BUSY must be ignored.
    do_mult("u_3x5_junk", 32'd3, 32'd5, 1'b0, 64'd15, lat(3), 1'b1);
    release_out("u_3x5_junk");
    @(posedge clk); @(negedge clk);
    chk("junk_no_second_busy", 64'(busy), 64'd0);

    do_mult("u_5x3", 32'd5, 32'd3, 1'b0, 64'd15, lat(2), 1'b0);
    release_out("u_5x3");
    do_mult("u_9x0", 32'd9, 32'd0, 1'b0, 64'd0, lat(1), 1'b0);
    release_out("u_9x0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
